// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data_memory port. Accepts LB/LBU/LH/LHU/LW/SB/SH/SW
//   requests from the EX/MEM stage and turns them into word-aligned accesses on
//   a word-wide, big-endian memory interface. Sub-word stores are done as a
//   read-modify-write. Load data is sign- or zero-extended before return.
//
// Configuration macro:
//   LSU_ALIGN_CHECK_EN  when defined, misaligned half/word requests and requests
//                       running past MEM_BYTES complete with resp_error=1, no
//                       memory write and rdata=0. When undefined resp_error is
//                       always 0 and low address bits are ignored.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             request channel (valid/ready), size 00=B 01=H 1x=W
//   resp_valid        one-cycle completion pulse, no back-pressure
//   resp_rdata        extended load data (0 for stores/errors)
//   resp_error        misaligned / out of range
//   mem_address       word-aligned address to data_memory
//   mem_write_data    word to write
//   mem_write_enable  write strobe (memory commits on negedge clk)
//   mem_read_data     combinational read word from data_memory
//   dbg_state         current FSM state (0=IDLE 1=ACCESS 2=MERGE 3=RESP)
//
// Handshake: a request transfers at a posedge where req_valid && req_ready;
// req_ready is high only in IDLE and never while reset is high. Request inputs
// are ignored in every other state. resp_valid is a single-cycle pulse that
// the consumer must take when it appears.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_we_q, mem_we_d;
  logic        req_err;

  // Select the addressed lane (big-endian) and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the word read during ACCESS.
  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] w;
    w = old;
    if (size == 2'b00) begin
      case (off)
        2'd0:    w[31:24] = wd[7:0];
        2'd1:    w[23:16] = wd[7:0];
        2'd2:    w[15:8]  = wd[7:0];
        default: w[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      w[15:0] = wd[15:0];
    end else begin
      w[31:16] = wd[15:0];
    end
    return w;
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  logic [2:0]  size_bytes;
  logic [32:0] req_end;
  logic        misalign;
  always_comb begin
    case (req_size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap past the range check.
    req_end  = {1'b0, req_address} + {30'd0, size_bytes};
    misalign = ((req_size == 2'b01) && req_address[0]) ||
               (req_size[1] && (req_address[1:0] != 2'b00));
    req_err  = misalign || (req_end > 33'(MEM_BYTES));
  end
`else
  assign req_err = 1'b0;
`endif

  assign req_ready        = (state_q == S_IDLE) && !reset;
  // Gate the strobe with reset so an aborted access never commits.
  assign mem_write_enable = mem_we_q && !reset;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign dbg_state        = state_q;

  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    uns_d            = uns_q;
    offset_d         = offset_q;
    wdata_d          = wdata_q;
    err_d            = err_q;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    resp_error_d     = resp_error_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_we_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d       = req_write;
          size_d        = req_size;
          uns_d         = req_unsigned;
          offset_d      = req_address[1:0];
          wdata_d       = req_wdata;
          err_d         = req_err;
          mem_address_d = {req_address[31:2], 2'b00};
          // A full-word store writes during ACCESS, so arm the strobe now.
          if (req_write && req_size[1] && !req_err) begin
            mem_we_d         = 1'b1;
            mem_write_data_d = req_wdata;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (err_q) begin
          resp_rdata_d = 32'd0;
          resp_error_d = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (!write_q) begin
          resp_rdata_d = extend_load(mem_read_data, size_q, offset_q, uns_q);
          resp_error_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (size_q[1]) begin
          resp_rdata_d = 32'd0;
          resp_error_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          mem_write_data_d = merge_word(mem_read_data, wdata_q, size_q, offset_q);
          mem_we_d         = 1'b1;
          state_d          = S_MERGE;
        end
      end
      S_MERGE: begin
        resp_rdata_d = 32'd0;
        resp_error_d = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      offset_q         <= 2'b00;
      wdata_q          <= 32'd0;
      err_q            <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'd0;
      resp_error_q     <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
      mem_we_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      offset_q         <= offset_d;
      wdata_q          <= wdata_d;
      err_q            <= err_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_error_q     <= resp_error_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_we_q         <= mem_we_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Bench for load_store_unit: a byte-addressed big-endian memory attached to
//   the memory port, a byte-level reference image updated with the expected
//   effect of every store, and a scoreboard queue of expected responses.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [9:0]  rd_base;
  int          write_count;
  int          resp_seen;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  always_comb begin
    rd_base       = {mem_address[9:2], 2'b00};
    mem_read_data = {mem[rd_base], mem[rd_base + 10'd1],
                     mem[rd_base + 10'd2], mem[rd_base + 10'd3]};
  end

  always @(negedge clk) begin
    if (mem_write_enable) begin
      mem[{mem_address[9:2], 2'b00}]         = mem_write_data[31:24];
      mem[{mem_address[9:2], 2'b00} + 10'd1] = mem_write_data[23:16];
      mem[{mem_address[9:2], 2'b00} + 10'd2] = mem_write_data[15:8];
      mem[{mem_address[9:2], 2'b00} + 10'd3] = mem_write_data[7:0];
      write_count = write_count + 1;
      last_waddr  = mem_address;
      last_wdata  = mem_write_data;
    end
    if (resp_valid) resp_seen = resp_seen + 1;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Expected load result straight from the byte image.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    logic [9:0]  b;
    logic [31:0] v;
    b = a[9:0];
    case (sz)
      2'b00: begin
        v = {24'd0, ref_mem[b]};
        if (!uns && v[7]) v[31:8] = 24'hFFFFFF;
      end
      2'b01: begin
        b = {b[9:1], 1'b0};
        v = {16'd0, ref_mem[b], ref_mem[b + 10'd1]};
        if (!uns && v[15]) v[31:16] = 16'hFFFF;
      end
      default: begin
        b = {b[9:2], 2'b00};
        v = {ref_mem[b], ref_mem[b + 10'd1], ref_mem[b + 10'd2], ref_mem[b + 10'd3]};
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] b;
    b = a[9:0];
    case (sz)
      2'b00: ref_mem[b] = wd[7:0];
      2'b01: begin
        b = {b[9:1], 1'b0};
        ref_mem[b]         = wd[15:8];
        ref_mem[b + 10'd1] = wd[7:0];
      end
      default: begin
        b = {b[9:2], 2'b00};
        ref_mem[b]         = wd[31:24];
        ref_mem[b + 10'd1] = wd[23:16];
        ref_mem[b + 10'd2] = wd[15:8];
        ref_mem[b + 10'd3] = wd[7:0];
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic [32:0] e;
    int          exp_lat;
    int          cyc;
    logic        busy_ready;
    exp_rd  = (w || exp_err) ? 32'd0 : ref_load(sz, uns, addr);
    exp_lat = (!exp_err && w && !sz[1]) ? 3 : 2;
    got     = 32'd0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_address  = addr;
    req_wdata    = wd;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({exp_err, exp_rd});
    if (w && !exp_err) ref_store(sz, addr, wd);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_address = $urandom;
    req_wdata   = $urandom;
    cyc = 1;
    busy_ready = 1'b0;
    while (!resp_valid && cyc < 10) begin
      busy_ready = busy_ready | req_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    e = exp_q.pop_front();
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      check("resp_rdata", resp_rdata, e[31:0]);
      check("resp_error", {31'd0, resp_error}, {31'd0, e[32]});
      check("latency", 32'(cyc), 32'(exp_lat));
      check("ready_while_busy", {31'd0, busy_ready | req_ready}, 32'd0);
      got = resp_rdata;
      @(posedge clk);
      #1;
      check("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
      check("ready_after_resp", {31'd0, req_ready}, 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    int          wc0;
    int          rs0;
    int          bad_bytes;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] addr;

    n_cmp = 0;
    n_bad = 0;
    write_count = 0;
    resp_seen = 0;
    last_waddr = 32'd0;
    last_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) poke(i, 8'h00);
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_address  = 32'd0;
    req_wdata    = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("ready_out_of_reset", {31'd0, req_ready}, 32'd1);

    // Loads from a known word
    poke(32'h10, 8'hDE);
    poke(32'h11, 8'hAD);
    poke(32'h12, 8'hBE);
    poke(32'h13, 8'hEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, got);
    check("lw_10", got, 32'hDEADBEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 1'b0, got);
    check("lb_11", got, 32'hFFFFFFAD);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 1'b0, got);
    check("lbu_11", got, 32'h000000AD);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b0, got);
    check("lh_12", got, 32'hFFFFBEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 1'b0, got);
    check("lhu_10", got, 32'h0000DEAD);

    // Sub-word store: one merged write
    wc0 = write_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 1'b0, got);
    check("sb_write_count", 32'(write_count - wc0), 32'd1);
    check("sb_write_addr", last_waddr, 32'h10);
    check("sb_write_data", last_wdata, 32'hDEAD55EF);

    // Word store followed immediately by a load of the same word
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, got);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0, got);
    check("lw_20", got, 32'h12345678);

    // Reset during MERGE of SH 0x14
    poke(32'h14, 8'h11);
    poke(32'h15, 8'h22);
    poke(32'h16, 8'h33);
    poke(32'h17, 8'h44);
    wc0 = write_count;
    rs0 = resp_seen;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'b01;
    req_unsigned = 1'b0;
    req_address  = 32'h14;
    req_wdata    = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sh_in_merge", {30'd0, dbg_state}, 32'd2);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_in_reset", {31'd0, req_ready}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", 32'(write_count - wc0), 32'd0);
    check("abort_no_resp", 32'(resp_seen - rs0), 32'd0);
    check("abort_mem_word", {mem[32'h14], mem[32'h15], mem[32'h16], mem[32'h17]}, 32'h11223344);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);

    // Alignment / range behaviour
`ifdef LSU_ALIGN_CHECK_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 1'b1, got);
    check("lw_11_err_rdata", got, 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 1'b1, got);
    wc0 = write_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h3FE, 32'hCAFEF00D, 1'b1, got);
    check("sw_3fe_no_write", 32'(write_count - wc0), 32'd0);
    wc0 = write_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h400, 32'h77, 1'b1, got);
    check("sb_400_no_write", 32'(write_count - wc0), 32'd0);
    do_req(1'b0, 2'b00, 1'b1, 32'h3FF, 32'd0, 1'b0, got);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 1'b0, got);
    check("lw_11_word", got, 32'hDEAD55EF);
    do_req(1'b1, 2'b10, 1'b0, 32'h3FE, 32'hCAFEF00D, 1'b0, got);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 1'b0, got);
    check("lw_3fc", got, 32'hCAFEF00D);
`endif

    // Random aligned traffic against the reference image
    for (int k = 0; k < 24; k++) begin
      w    = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 2));
      addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      if (sz == 2'b00) addr = addr + 32'($urandom_range(0, 3));
      else if (sz == 2'b01) addr = addr + 32'($urandom_range(0, 1)) * 2;
      do_req(w, sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, got);
    end

    bad_bytes = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
    check("mem_image", 32'(bad_bytes), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
